// File: rtl/fp_mult_pkg.sv
// Shared definitions for the floating-point multiplier: default format,
// operand classes and width-generic helpers for bias and exponent limits.
package fp_mult_pkg;

    // Default format is bfloat16.
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 7;
    localparam int BIAS      = (1 << (EXP_W_DEF - 1)) - 1;
    localparam int EXP_MAX   = (1 << EXP_W_DEF) - 1;
    localparam int FMT_W     = 1 + EXP_W_DEF + MAN_W_DEF;

    // Canonical special encodings for the default format.
    localparam logic [FMT_W-1:0] QNAN_BF16 = 16'h7FC0;
    localparam logic [FMT_W-1:0] INF_BF16  = 16'h7F80;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int exp_max_of(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Denormals (exp = 0, frac != 0) are deliberately classed as zero.
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_nz);
        if (exp_zero)      return ZERO;
        else if (exp_ones) return frac_nz ? NAN : INF;
        else               return NORM;
    endfunction

    // Result class for a product, highest-priority special first.
    function automatic fp_class_e resolve(input fp_class_e ca, input fp_class_e cb);
        if (ca == NAN || cb == NAN ||
            (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) return NAN;
        else if (ca == INF || cb == INF)                                 return INF;
        else if (ca == ZERO || cb == ZERO)                               return ZERO;
        else                                                             return NORM;
    endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result stream bundle for one multiplier lane.
interface fp_mult_pipe_if
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [2:0]   flags;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, out, flags);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, out, flags);
endinterface

// File: rtl/fp_mult_round.sv
// Normalise, round and range-check the raw mantissa product of the last stage.
module fp_mult_round
    import fp_mult_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MAN_W  = MAN_W_DEF,
    parameter int RNE_EN = 1
) (
    input  logic [2*MAN_W+1:0]      prod,
    input  logic signed [EXP_W+1:0] exp_in,
    output logic [MAN_W-1:0]        frac_out,
    output logic [EXP_W-1:0]        exp_out,
    output logic                    overflow,
    output logic                    underflow
);
    localparam logic signed [EXP_W+1:0] E_MAX_S = (EXP_W+2)'(exp_max_of(EXP_W));

    logic                    hi;
    logic [MAN_W-1:0]        frac;
    logic                    guard;
    logic                    sticky;
    logic                    inc;
    logic                    carry;
    logic [MAN_W-1:0]        frac_r;
    logic signed [EXP_W+1:0] e1;

    // Pick the fraction window by product magnitude, then round and fix the exponent.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        hi     = prod[2*MAN_W+1];
        frac   = hi ? prod[2*MAN_W:MAN_W+1]  : prod[2*MAN_W-1:MAN_W];
        guard  = hi ? prod[MAN_W]            : prod[MAN_W-1];
        sticky = hi ? (|prod[MAN_W-1:0])     : (|prod[MAN_W-2:0]);
        inc    = (RNE_EN != 0) && guard && (sticky || frac[0]);
        // A carry out leaves frac_r at zero, which is exactly 1.0 after re-normalising.
        {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(inc);
        e1 = exp_in + signed'({{(EXP_W+1){1'b0}}, hi})
                    + signed'({{(EXP_W+1){1'b0}}, carry});
        overflow  = (e1 >= E_MAX_S);
        underflow = (e1 <= 0);
        frac_out  = frac_r;
        exp_out   = e1[EXP_W-1:0];
    end
endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier with a single global stall.
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MAN_W  = MAN_W_DEF,
    parameter int RNE_EN = 1
) (
    input logic           clk,
    input logic           rst,
    fp_mult_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(bias_of(EXP_W));
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;
    logic out_valid_q;

    logic             s1_valid, s1_sign;
    logic [EXP_W-1:0] s1_ea, s1_eb;
    logic [MAN_W:0]   s1_ma, s1_mb;
    fp_class_e        s1_cls;

    logic                    s2_valid, s2_sign;
    logic [PW-1:0]           s2_prod;
    logic signed [EXP_W+1:0] s2_exp;
    fp_class_e               s2_cls;

    logic [W-1:0] out_q;
    logic [2:0]   flags_q;

    logic [W-1:0]     res_out;
    logic [2:0]       res_flags;
    logic [MAN_W-1:0] r_frac;
    logic [EXP_W-1:0] r_exp;
    logic             r_ovf, r_unf;

    fp_class_e cls_a, cls_b;

    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.flags     = flags_q;

    assign cls_a = classify(bus.a[W-2:MAN_W] == '0, &bus.a[W-2:MAN_W], |bus.a[MAN_W-1:0]);
    assign cls_b = classify(bus.b[W-2:MAN_W] == '0, &bus.b[W-2:MAN_W], |bus.b[MAN_W-1:0]);

    // S1: unpack operands and resolve the special-value class of the product.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update together.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_cls   <= ZERO;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= bus.a[W-1] ^ bus.b[W-1];
            s1_ea    <= bus.a[W-2:MAN_W];
            s1_eb    <= bus.b[W-2:MAN_W];
            s1_ma    <= {1'b1, bus.a[MAN_W-1:0]};
            s1_mb    <= {1'b1, bus.b[MAN_W-1:0]};
            s1_cls   <= resolve(cls_a, cls_b);
        end
    end

    // S2: full mantissa product and biased exponent sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_prod  <= '0;
            s2_exp   <= '0;
            s2_cls   <= ZERO;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
            s2_exp   <= signed'({2'b00, s1_ea}) + signed'({2'b00, s1_eb}) - BIAS_S;
            s2_cls   <= s1_cls;
        end
    end

    fp_mult_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .RNE_EN(RNE_EN)
    ) u_round (
        .prod     (s2_prod),
        .exp_in   (s2_exp),
        .frac_out (r_frac),
        .exp_out  (r_exp),
        .overflow (r_ovf),
        .underflow(r_unf)
    );

    // S3 result select: specials override the rounded normal path.
    always_comb begin
        res_out   = {s2_sign, r_exp, r_frac};
        res_flags = 3'b000;
        case (s2_cls)
            NAN: begin
                res_out   = QNAN;
                res_flags = 3'b100;
            end
            INF:  res_out = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ZERO: res_out = {s2_sign, {(W-1){1'b0}}};
            default: begin
                if (r_ovf) begin
                    res_out   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    res_flags = 3'b010;
                end else if (r_unf) begin
                    res_out   = {s2_sign, {(W-1){1'b0}}};
                    res_flags = 3'b001;
                end
            end
        endcase
    end

    // S3 register: result and flags, cleared on a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= 3'b000;
        end else if (advance) begin
            out_valid_q <= s2_valid;
            out_q       <= s2_valid ? res_out   : '0;
            flags_q     <= s2_valid ? res_flags : 3'b000;
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench: bfloat16 (RNE and truncate) and fp16 lanes.
module tb_fp_mult_pipe;
    import fp_mult_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fp_mult_pipe_if #(.EXP_W(8), .MAN_W(7))  bf_if ();
    fp_mult_pipe_if #(.EXP_W(8), .MAN_W(7))  tr_if ();
    fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) h_if ();

    fp_mult_pipe #(.EXP_W(8), .MAN_W(7), .RNE_EN(1))  u_bf (.clk(clk), .rst(rst), .bus(bf_if));
    fp_mult_pipe #(.EXP_W(8), .MAN_W(7), .RNE_EN(0))  u_tr (.clk(clk), .rst(rst), .bus(tr_if));
    fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .RNE_EN(1)) u_h  (.clk(clk), .rst(rst), .bus(h_if));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane select: 0 = bfloat16 RNE, 1 = bfloat16 truncate, 2 = fp16.
    task automatic drive(input int u, input logic v, input logic [15:0] a, input logic [15:0] b);
        case (u)
            0:       begin bf_if.in_valid = v; bf_if.a = a; bf_if.b = b; end
            1:       begin tr_if.in_valid = v; tr_if.a = a; tr_if.b = b; end
            default: begin h_if.in_valid  = v; h_if.a  = a; h_if.b  = b; end
        endcase
    endtask

    function automatic logic [19:0] sample(input int u);
        case (u)
            0:       return {bf_if.out_valid, bf_if.flags, bf_if.out};
            1:       return {tr_if.out_valid, tr_if.flags, tr_if.out};
            default: return {h_if.out_valid, h_if.flags, h_if.out};
        endcase
    endfunction

    // One isolated operation: accept, wait (bounded) for the result, check all of it.
    task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_out, input logic [2:0] exp_flags,
                          input string tag);
        logic [19:0] s;
        int          lat;
        logic        seen;
        @(negedge clk);
        drive(u, 1'b1, a, b);
        lat  = 0;
        seen = 1'b0;
        s    = '0;
        while (!seen && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) drive(u, 1'b0, 16'h0000, 16'h0000);
            s    = sample(u);
            seen = s[19];
        end
        check({tag, " valid"},   32'(seen),      32'd1);
        check({tag, " latency"}, 32'(lat),       32'd3);
        check({tag, " out"},     32'(s[15:0]),   32'(exp_out));
        check({tag, " flags"},   32'(s[18:16]),  32'(exp_flags));
    endtask

    initial begin
        int sent;
        int got;
        bf_if.out_ready = 1'b1;
        tr_if.out_ready = 1'b1;
        h_if.out_ready  = 1'b1;
        drive(0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 16'h0000, 16'h0000);
        drive(2, 1'b0, 16'h0000, 16'h0000);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst out_valid", 32'(bf_if.out_valid), 32'd0);
        check("rst out",       32'(bf_if.out),       32'd0);
        check("rst flags",     32'(bf_if.flags),     32'd0);
        check("rst in_ready",  32'(bf_if.in_ready),  32'd1);
        rst = 1'b0;

        // Basic arithmetic.
        run_op(0, 16'h3F80, 16'h3F80, 16'h3F80, 3'b000, "one_x_one");
        run_op(0, 16'h4000, 16'hC040, 16'hC0C0, 3'b000, "two_x_m3");
        // Rounding.
        run_op(0, 16'h3F81, 16'h3F81, 16'h3F82, 3'b000, "rne_down");
        run_op(0, 16'h3F81, 16'h3FC0, 16'h3FC2, 3'b000, "rne_tie_even");
        run_op(1, 16'h3F81, 16'h3FC0, 16'h3FC1, 3'b000, "truncate");
        // Range.
        run_op(0, 16'h7F00, 16'h7F00, INF_BF16, 3'b010, "overflow");
        run_op(0, 16'h0080, 16'h0080, 16'h0000, 3'b001, "underflow");
        run_op(0, 16'h0001, 16'h3F80, 16'h0000, 3'b000, "denorm_flush");
        // Specials.
        run_op(0, 16'h7F80, 16'h0000, QNAN_BF16, 3'b100, "inf_x_zero");
        run_op(0, 16'hFF80, 16'h4000, 16'hFF80, 3'b000, "neg_inf");
        run_op(0, 16'h7FC1, 16'h3F80, QNAN_BF16, 3'b100, "nan_in");
        run_op(0, 16'h8000, 16'h4000, 16'h8000, 3'b000, "neg_zero");
        // fp16 lane.
        run_op(2, 16'h3C00, 16'h4000, 16'h4000, 3'b000, "fp16_one_x_two");

        // Back-pressure: 8 back-to-back ops (x * 2.0), downstream stalls for 4 cycles.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            bf_if.out_ready = !(cyc >= 4 && cyc < 8);
            drive(0, sent < 8, 16'h3F80 + 16'(sent), 16'h4000);
            #1;
            if (!bf_if.out_ready) begin
                check("bp in_ready stalled", 32'(bf_if.in_ready),  32'd0);
                check("bp out_valid held",   32'(bf_if.out_valid), 32'd1);
                check("bp out held",         32'(bf_if.out),       32'(16'h4000 + 16'(got)));
                check("bp flags held",       32'(bf_if.flags),     32'd0);
            end
            if (bf_if.out_valid && bf_if.out_ready) begin
                check("bp order", 32'(bf_if.out), 32'(16'h4000 + 16'(got)));
                got++;
            end
            if (bf_if.in_valid && bf_if.in_ready) sent++;
        end
        @(negedge clk);
        drive(0, 1'b0, 16'h0000, 16'h0000);
        bf_if.out_ready = 1'b1;
        check("bp sent count", 32'(sent), 32'd8);
        check("bp got count",  32'(got),  32'd8);
        repeat (4) @(negedge clk);
        check("bp no duplicate", 32'(bf_if.out_valid), 32'd0);

        // Reset with three items in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 16'h3F80 + 16'(i), 16'h3F80);
        end
        @(negedge clk);
        drive(0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", 32'(bf_if.out_valid), 32'd0);
        check("mid rst out",       32'(bf_if.out),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 16'h4000, 16'h4000, 16'h4080, 3'b000, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
